// File: rtl/machine_trace_dump_pkg.sv
// machine_trace_dump_pkg: record kinds, controller states and a saturating counter helper
package machine_trace_dump_pkg;
    typedef enum logic [1:0] {KIND_PC = 2'b00, KIND_REG = 2'b01, KIND_MEM = 2'b10} kind_t;
    typedef enum logic [2:0] {IDLE, RUN, DUMP_REG, DUMP_MEM, DONE} state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/machine_trace_dump_out_reg.sv
// machine_trace_dump_out_reg: one-entry valid/ready output register holding a trace record
module machine_trace_dump_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         ready,
    input  logic [1:0]   ld_kind,
    input  logic [W-1:0] ld_data,
    input  logic         ld_last,
    output logic         free,
    output logic         valid,
    output logic [1:0]   kind,
    output logic [W-1:0] data,
    output logic         last
);
    assign free = !valid || ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            kind  <= 2'b00;
            data  <= '0;
            last  <= 1'b0;
        end else if (free) begin
            valid <= load;
            if (load) begin
                kind <= ld_kind;
                data <= ld_data;
                last <= ld_last;
            end
        end
    end
endmodule

// File: rtl/machine_trace_dump.sv
// machine_trace_dump: traces retired PCs of a machine, then dumps its register file and a
// data-memory window over one valid/ready record channel once the run halts or times out.
module machine_trace_dump
    import machine_trace_dump_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter int          DATA_W    = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] MEM_BASE  = 32'h4000,
    parameter int          MEM_WORDS = 4,
    parameter logic [31:0] TIMEOUT   = 32'd64,
    parameter logic [31:0] HALT_INST = 32'h0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        inst_valid,
    input  logic [PC_W-1:0]                             pc,
    input  logic [31:0]                                 inst,
    output logic                                        cpu_stall,
    output logic [4:0]                                  rf_raddr,
    input  logic [DATA_W-1:0]                           rf_rdata,
    output logic [31:0]                                 mem_raddr,
    input  logic [DATA_W-1:0]                           mem_rdata,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [1:0]                                  out_kind,
    output logic [(DATA_W > PC_W ? DATA_W : PC_W)-1:0]  out_data,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        halted,
    output logic                                        timed_out,
    output logic [31:0]                                 retired
);
    localparam int          OUT_W  = DATA_W > PC_W ? DATA_W : PC_W;
    localparam logic [4:0]  K_LAST = 5'(NUM_REGS - 1);
    localparam logic [31:0] J_LAST = 32'(MEM_WORDS - 1);
    state_t             state;
    logic [4:0]         k;
    logic [31:0]        j;
    logic [31:0]        next_retired;
    logic               free, accept, load, ld_last;
    logic [1:0]         ld_kind;
    logic [OUT_W-1:0]   ld_data;
    always_comb begin
        cpu_stall    = state == RUN && out_valid && !out_ready && inst_valid;
        accept       = state == RUN && inst_valid && !cpu_stall;
        load         = free && (accept || state == DUMP_REG || state == DUMP_MEM);
        ld_kind      = state == RUN ? KIND_PC : state == DUMP_REG ? KIND_REG : KIND_MEM;
        ld_data      = state == RUN ? OUT_W'(pc) : state == DUMP_REG ? OUT_W'(rf_rdata) : OUT_W'(mem_rdata);
        ld_last      = state == DUMP_REG ? (MEM_WORDS == 0 && k == K_LAST) : (state == DUMP_MEM && j == J_LAST);
        rf_raddr     = state == DUMP_REG ? k : 5'd0;
        mem_raddr    = state == DUMP_MEM ? MEM_BASE + j : 32'd0;
        busy         = state == RUN || state == DUMP_REG || state == DUMP_MEM || (state == DONE && out_valid);
        next_retired = sat_inc(retired);
    end
    // Halt is tested before the timeout so it wins when both hit on one instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= 5'd0;
            j         <= 32'd0;
            retired   <= 32'd0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: if (accept) begin
                    retired <= next_retired;
                    if (inst == HALT_INST) begin
                        halted <= 1'b1;
                        state  <= DUMP_REG;
                    end else if (next_retired == TIMEOUT) begin
                        timed_out <= 1'b1;
                        state     <= DUMP_REG;
                    end
                end
                DUMP_REG: if (free) begin
                    k <= k + 5'd1;
                    if (k == K_LAST) state <= MEM_WORDS == 0 ? DONE : DUMP_MEM;
                end
                DUMP_MEM: if (free) begin
                    j <= j + 32'd1;
                    if (j == J_LAST) state <= DONE;
                end
                default: ;
            endcase
        end
    end
    machine_trace_dump_out_reg #(.W(OUT_W)) u_out (
        .clk(clk), .reset(reset), .load(load), .ready(out_ready),
        .ld_kind(ld_kind), .ld_data(ld_data), .ld_last(ld_last),
        .free(free), .valid(out_valid), .kind(out_kind), .data(out_data), .last(out_last)
    );
endmodule

// File: tb/tb_machine_trace_dump.sv
// tb_machine_trace_dump: random programs and back-pressure against a queue-based record model
module tb_machine_trace_dump;
    logic clk = 0, reset = 0, start = 0, inst_valid = 0, out_ready = 0;
    logic [31:0] pc = 0, inst = 0;
    logic cpu_stall, out_valid, out_last, busy, halted, timed_out;
    logic [4:0] rf_raddr;
    logic [31:0] rf_rdata, mem_raddr, mem_rdata, out_data, retired;
    logic [1:0] out_kind;
    logic cpu_stall2, out_valid2, out_last2, busy2, halted2, timed_out2;
    logic [4:0] rf_raddr2;
    logic [31:0] rf_rdata2, mem_raddr2, out_data2, retired2;
    logic [1:0] out_kind2;
    logic [31:0] rf [32];
    logic [31:0] memv [4];
    logic [31:0] pcs[$], insts[$];
    logic [34:0] exp_q[$], got_q[$];
    int n_acc, checks = 0, failures = 0, cnt2, last_at2;
    bit exp_halt;

    always #5 clk = ~clk;
    assign rf_rdata  = rf[rf_raddr];
    assign rf_rdata2 = rf[rf_raddr2];
    assign mem_rdata = (mem_raddr - 32'h4000) < 32'd4 ? memv[mem_raddr[1:0]] : 32'hbad0_0000 ^ mem_raddr;

    machine_trace_dump dut (
        .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid), .pc(pc), .inst(inst),
        .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_data(out_data), .out_last(out_last), .busy(busy), .halted(halted),
        .timed_out(timed_out), .retired(retired)
    );
    machine_trace_dump #(.TIMEOUT(32'd4), .MEM_WORDS(0)) dut2 (
        .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid), .pc(pc), .inst(inst),
        .cpu_stall(cpu_stall2), .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .mem_raddr(mem_raddr2),
        .mem_rdata(32'h0), .out_valid(out_valid2), .out_ready(out_ready), .out_kind(out_kind2),
        .out_data(out_data2), .out_last(out_last2), .busy(busy2), .halted(halted2),
        .timed_out(timed_out2), .retired(retired2)
    );

    always @(negedge clk) begin
        if (!reset) begin
            cnt2 = 0;
            last_at2 = 0;
        end else if (out_valid2 && out_ready) begin
            cnt2++;
            if (out_last2) last_at2 = cnt2;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build(input int n, input int halt_at, input logic [31:0] base, input int wrap);
        int h = -1;
        pcs.delete();
        insts.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pcs.push_back(base + 32'(4 * (i % wrap)));
            insts.push_back(i == halt_at ? 32'h0 : ($urandom | 32'h1));
            if (h < 0 && i == halt_at) h = i;
        end
        exp_halt = h >= 0 && h + 1 <= 64;
        n_acc = exp_halt ? h + 1 : 64;
        for (int i = 0; i < n_acc; i++) exp_q.push_back({1'b0, 2'b00, pcs[i]});
        for (int r = 0; r < 32; r++) exp_q.push_back({1'b0, 2'b01, rf[r]});
        for (int m = 0; m < 4; m++) exp_q.push_back({m == 3, 2'b10, memv[m]});
    endtask

    task automatic do_reset();
        @(posedge clk) #1 reset = 0;
        start = 0;
        inst_valid = 0;
        out_ready = 0;
        @(negedge clk);
        check("reset_state", {out_valid, busy, cpu_stall, halted, timed_out, out_last, retired}, 64'h0);
        @(posedge clk) #1 reset = 1;
    endtask

    task automatic run(input int mode, input int abort_reg);
        int issued = 0, cyc = 0, regs_acc = 0;
        bit done = 0;
        got_q.delete();
        @(posedge clk) #1 start = 1;
        while (!done && cyc < 3000) begin
            @(posedge clk) #1 start = 0;
            out_ready = mode == 0 ? 1'b1 : (mode == 1 && issued < n_acc) ? (cyc % 3 == 0) : 1'($urandom);
            if (abort_reg > 0 && regs_acc >= abort_reg - 1) out_ready = 0;
            inst_valid = issued < n_acc;
            pc = inst_valid ? pcs[issued] : 32'h0;
            inst = inst_valid ? insts[issued] : 32'h1;
            @(negedge clk);
            if (inst_valid) check("stall", cpu_stall, out_valid && !out_ready);
            if (inst_valid && !cpu_stall) issued++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_kind, out_data});
                if (out_kind == 2'b01) regs_acc++;
            end
            if (abort_reg > 0) done = regs_acc == abort_reg - 1 && out_valid && !out_ready && out_kind == 2'b01;
            else done = got_q.size() == exp_q.size() && !busy;
            cyc++;
        end
        check("budget", done, 1);
        if (abort_reg == 0) begin
            check("count", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("rec%0d", i), got_q[i], exp_q[i]);
            check("flags", {halted, timed_out}, {exp_halt, !exp_halt});
            check("retired", retired, 64'(n_acc));
            check("drained", out_valid, 0);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        rf[11] = 123;
        rf[12] = 100;
        rf[13] = 268501000;
        rf[14] = 268501004;
        for (int m = 0; m < 4; m++) memv[m] = $urandom;
        do_reset();
        build(4, 3, 32'h0, 4);
        run(0, 0);
        check("r13_val", got_q.size() > 17 ? got_q[17] : 35'h0, {3'b001, 32'h1001_0008});
        do_reset();
        build(80, -1, 32'h100, 4);
        run(2, 0);
        do_reset();
        build(12, 11, 32'h400, 12);
        run(1, 0);
        do_reset();
        build(4, 3, 32'h40, 4);
        run(0, 0);
        check("t4_flags", {halted2, timed_out2}, 2'b10);
        check("t4_retired", retired2, 4);
        check("t4_count", cnt2, 36);
        check("t4_last", last_at2, 36);
        do_reset();
        build(4, 3, 32'h0, 4);
        run(0, 10);
        check("pend10", out_data, rf[9]);
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk) #1 reset = 1;
        run(0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
